// File: rtl/boot_pkg.sv
// ============================================================================
// boot_pkg : shared types and constants for the boot-time ROM-to-RAM copier
// Rev 1.0
// ============================================================================
`default_nettype none

package boot_pkg;

  localparam int ROM_WORDS = 16;
  localparam int ROM_AW    = 4;
  localparam int BOOT_BASE = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/boot_loader_if.sv
// ============================================================================
// boot_loader_if : boot ROM read port and RAM write port seen by the copier
// Rev 1.0
// ============================================================================
`default_nettype none

interface boot_loader_if #(
  parameter int RAM_AW = 12
) ();

  logic                        rom_cs;
  logic                        rom_we;
  logic [boot_pkg::ROM_AW-1:0] rom_addr;
  logic [15:0]                 rom_din;
  logic [15:0]                 rom_dout;

  logic                        ram_cs;
  logic                        ram_we;
  logic [RAM_AW-1:0]           ram_addr;
  logic [15:0]                 ram_din;
  logic                        ram_wait;

  modport master (
    output rom_cs, rom_we, rom_addr, rom_din,
    input  rom_dout,
    output ram_cs, ram_we, ram_addr, ram_din,
    input  ram_wait
  );

  modport slave (
    input  rom_cs, rom_we, rom_addr, rom_din,
    output rom_dout,
    input  ram_cs, ram_we, ram_addr, ram_din,
    output ram_wait
  );

endinterface

`default_nettype wire

// File: rtl/boot_loader.sv
// ============================================================================
// boot_loader : copies the boot ROM into RAM while holding the CPU in halt
// Rev 1.0
// ============================================================================
`default_nettype none

module boot_loader
  import boot_pkg::*;
#(
  parameter int WORDS      = ROM_WORDS,
  parameter int RAM_AW     = 12,
  parameter int BASE       = BOOT_BASE,
  parameter bit AUTO_START = 1'b1
) (
  input  logic                 romclk,
  input  logic                 rst,
  input  logic                 start,
  boot_loader_if.master        bus,
  output logic                 cpu_halt,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          checksum
);

  localparam logic [ROM_AW-1:0] LAST_IDX  = ROM_AW'(WORDS - 1);
  localparam logic [RAM_AW-1:0] BASE_ADDR = RAM_AW'(BASE);

  state_e              state_q, state_d;
  logic [ROM_AW-1:0]   index_q, index_d;
  logic [15:0]         data_q, data_d;
  logic [15:0]         checksum_q, checksum_d;
  logic                rom_cs_q, rom_cs_d;
  logic [ROM_AW-1:0]   rom_addr_q, rom_addr_d;
  logic                ram_cs_q, ram_cs_d;
  logic [RAM_AW-1:0]   ram_addr_q, ram_addr_d;
  logic [15:0]         ram_din_q, ram_din_d;
  logic                busy_q, busy_d;
  logic                halt_q, halt_d;
  logic                done_q, done_d;

  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    data_d     = data_q;
    checksum_d = checksum_q;

    unique case (state_q)
      IDLE: begin
        if (AUTO_START || start) begin
          state_d    = RD;
          index_d    = '0;
          checksum_d = '0;
        end
      end
      RD: begin
        data_d  = bus.rom_dout;
        state_d = WR;
      end
      WR: begin
        if (!bus.ram_wait) begin
          checksum_d = checksum_q + data_q;
          if (index_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            index_d = index_q + ROM_AW'(1);
            state_d = RD;
          end
        end
      end
      DONE: begin
        if (start) begin
          state_d    = RD;
          index_d    = '0;
          checksum_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they are registered yet
    // line up with the state they belong to.
    rom_cs_d   = (state_d == RD);
    rom_addr_d = rom_cs_d ? index_d : rom_addr_q;
    ram_cs_d   = (state_d == WR);
    ram_addr_d = ram_cs_d ? (BASE_ADDR + RAM_AW'(index_d)) : ram_addr_q;
    ram_din_d  = ram_cs_d ? data_d : ram_din_q;
    busy_d     = rom_cs_d || ram_cs_d;
    halt_d     = (state_d != DONE);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge romclk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      index_q    <= '0;
      data_q     <= '0;
      checksum_q <= '0;
      rom_cs_q   <= 1'b0;
      rom_addr_q <= '0;
      ram_cs_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      busy_q     <= 1'b0;
      halt_q     <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      data_q     <= data_d;
      checksum_q <= checksum_d;
      rom_cs_q   <= rom_cs_d;
      rom_addr_q <= rom_addr_d;
      ram_cs_q   <= ram_cs_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      busy_q     <= busy_d;
      halt_q     <= halt_d;
      done_q     <= done_d;
    end
  end

  assign bus.rom_cs   = rom_cs_q;
  assign bus.rom_we   = 1'b0;
  assign bus.rom_addr = rom_addr_q;
  assign bus.rom_din  = '0;
  assign bus.ram_cs   = ram_cs_q;
  assign bus.ram_we   = ram_cs_q;
  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_din  = ram_din_q;

  assign cpu_halt = halt_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign checksum = checksum_q;

endmodule

`default_nettype wire

// File: tb/tb_boot_loader.sv
// ============================================================================
// tb_boot_loader : self-checking bench for boot_loader (two configurations)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_boot_loader;

  logic        romclk;
  logic        rst;
  logic        start_a, start_b;
  logic        halt_a, busy_a, done_a;
  logic        halt_b, busy_b, done_b;
  logic [15:0] sum_a, sum_b;

  int n_vec = 0;
  int n_mis = 0;

  typedef struct packed {
    logic [11:0] addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    logic        wt;
    logic        rom_cs;
    logic [3:0]  rom_addr;
    logic        ram_cs;
    logic [11:0] ram_addr;
    logic [15:0] ram_din;
    logic        busy;
  } vec_t;

  wr_t  q_a[$];
  wr_t  q_b[$];
  vec_t vec[12];

  boot_loader_if #(.RAM_AW(12)) bus_a ();
  boot_loader_if #(.RAM_AW(12)) bus_b ();

  boot_loader dut_a (
    .romclk   (romclk),
    .rst      (rst),
    .start    (start_a),
    .bus      (bus_a),
    .cpu_halt (halt_a),
    .busy     (busy_a),
    .done     (done_a),
    .checksum (sum_a)
  );

  boot_loader #(
    .WORDS      (16),
    .RAM_AW     (12),
    .BASE       (12'hFFC),
    .AUTO_START (1'b0)
  ) dut_b (
    .romclk   (romclk),
    .rst      (rst),
    .start    (start_b),
    .bus      (bus_b),
    .cpu_halt (halt_b),
    .busy     (busy_b),
    .done     (done_b),
    .checksum (sum_b)
  );

  function automatic logic [15:0] rom_word(input logic [3:0] a);
    case (a)
      4'd0:    rom_word = 16'hF200;
      4'd1:    rom_word = 16'h4000;
      4'd2:    rom_word = 16'hF800;
      4'd3:    rom_word = 16'h1007;
      4'd4:    rom_word = 16'hF400;
      4'd5:    rom_word = 16'h3010;
      4'd6:    rom_word = 16'h4000;
      4'd7:    rom_word = 16'h0007;
      default: rom_word = 16'h0000;
    endcase
  endfunction

  // ROM model returns garbage when deselected so late sampling is exposed
  assign bus_a.rom_dout = bus_a.rom_cs ? rom_word(bus_a.rom_addr) : 16'hDEAD;
  assign bus_b.rom_dout = bus_b.rom_cs ? rom_word(bus_b.rom_addr) : 16'hDEAD;

  initial romclk = 1'b0;
  always #5 romclk = ~romclk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge romclk);
    #1;
  endtask

  task automatic push_a();
    for (int i = 0; i < 16; i++) q_a.push_back({12'(i), rom_word(4'(i))});
  endtask

  task automatic push_b();
    for (int i = 0; i < 16; i++) q_b.push_back({12'(12'hFFC + i), rom_word(4'(i))});
  endtask

  // Scoreboards: a write completes on the edge after a negedge with cs && !wait
  always @(negedge romclk) begin
    if (!rst) begin
      if (bus_a.rom_cs && bus_a.ram_cs) chk("a_rom_ram_overlap", 1, 0);
      if (bus_a.ram_cs && bus_a.ram_we && !bus_a.ram_wait) begin
        chk("a_wr_expected", 32'(q_a.size() > 0), 1);
        if (q_a.size() > 0) begin
          wr_t e;
          e = q_a.pop_front();
          chk("a_wr_addr", 32'(bus_a.ram_addr), 32'(e.addr));
          chk("a_wr_data", 32'(bus_a.ram_din), 32'(e.data));
        end
      end
      if (bus_b.rom_cs && bus_b.ram_cs) chk("b_rom_ram_overlap", 1, 0);
      if (bus_b.ram_cs && bus_b.ram_we && !bus_b.ram_wait) begin
        chk("b_wr_expected", 32'(q_b.size() > 0), 1);
        if (q_b.size() > 0) begin
          wr_t e;
          e = q_b.pop_front();
          chk("b_wr_addr", 32'(bus_b.ram_addr), 32'(e.addr));
          chk("b_wr_data", 32'(bus_b.ram_din), 32'(e.data));
        end
      end
    end
  end

  initial begin
    int n;

    vec[0]  = '{1'b0, 1'b0, 4'h0, 1'b0, 12'h000, 16'h0000, 1'b0};
    vec[1]  = '{1'b0, 1'b1, 4'h0, 1'b0, 12'h000, 16'h0000, 1'b1};
    vec[2]  = '{1'b0, 1'b0, 4'h0, 1'b1, 12'h000, 16'hF200, 1'b1};
    vec[3]  = '{1'b0, 1'b1, 4'h1, 1'b0, 12'h000, 16'h0000, 1'b1};
    vec[4]  = '{1'b0, 1'b0, 4'h0, 1'b1, 12'h001, 16'h4000, 1'b1};
    vec[5]  = '{1'b0, 1'b1, 4'h2, 1'b0, 12'h000, 16'h0000, 1'b1};
    vec[6]  = '{1'b1, 1'b0, 4'h0, 1'b1, 12'h002, 16'hF800, 1'b1};
    vec[7]  = '{1'b1, 1'b0, 4'h0, 1'b1, 12'h002, 16'hF800, 1'b1};
    vec[8]  = '{1'b1, 1'b0, 4'h0, 1'b1, 12'h002, 16'hF800, 1'b1};
    vec[9]  = '{1'b0, 1'b0, 4'h0, 1'b1, 12'h002, 16'hF800, 1'b1};
    vec[10] = '{1'b0, 1'b1, 4'h3, 1'b0, 12'h000, 16'h0000, 1'b1};
    vec[11] = '{1'b0, 1'b0, 4'h0, 1'b1, 12'h003, 16'h1007, 1'b1};

    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    bus_a.ram_wait = 1'b0;
    bus_b.ram_wait = 1'b0;
    repeat (3) next_cycle();

    chk("reset_flags", {29'd0, halt_a, busy_a, done_a}, 32'b100);
    chk("reset_strobes", {28'd0, bus_a.rom_cs, bus_a.rom_we, bus_a.ram_cs, bus_a.ram_we}, 0);
    chk("reset_addr", {16'd0, bus_a.rom_addr, bus_a.ram_addr}, 0);
    chk("reset_din_sum", {bus_a.ram_din, sum_a}, 0);

    // Copy with a three-cycle stall on word 2
    push_a();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("v%0d_rom_cs", i), 32'(bus_a.rom_cs), 32'(vec[i].rom_cs));
      chk($sformatf("v%0d_ram_cs", i), 32'(bus_a.ram_cs), 32'(vec[i].ram_cs));
      chk($sformatf("v%0d_busy", i), 32'(busy_a), 32'(vec[i].busy));
      chk($sformatf("v%0d_halt_done", i), {30'd0, halt_a, done_a}, 32'b10);
      if (vec[i].rom_cs) chk($sformatf("v%0d_rom_addr", i), 32'(bus_a.rom_addr), 32'(vec[i].rom_addr));
      if (vec[i].ram_cs) begin
        chk($sformatf("v%0d_ram_addr", i), 32'(bus_a.ram_addr), 32'(vec[i].ram_addr));
        chk($sformatf("v%0d_ram_din", i), 32'(bus_a.ram_din), 32'(vec[i].ram_din));
      end
      bus_a.ram_wait = vec[i].wt;
      next_cycle();
    end
    repeat (23) next_cycle();
    chk("stall_done_c35", {30'd0, done_a, halt_a}, 32'b01);
    next_cycle();
    chk("stall_done_c36", {29'd0, done_a, halt_a, busy_a}, 32'b100);
    chk("stall_checksum", 32'(sum_a), 32'h9E1E);
    chk("stall_queue_empty", 32'(q_a.size()), 0);

    // Restart from DONE, with an ignored start mid-copy
    push_a();
    start_a = 1'b1;
    next_cycle();
    start_a = 1'b0;
    chk("restart_flags", {29'd0, done_a, halt_a, busy_a}, 32'b011);
    chk("restart_rd", {27'd0, bus_a.rom_cs, bus_a.rom_addr}, 32'h10);
    chk("restart_sum_clr", 32'(sum_a), 0);
    repeat (5) next_cycle();
    start_a = 1'b1;
    next_cycle();
    start_a = 1'b0;
    repeat (25) next_cycle();
    chk("midstart_c32", {30'd0, done_a, busy_a}, 32'b01);
    next_cycle();
    chk("midstart_c33", {30'd0, done_a, halt_a}, 32'b10);
    chk("midstart_checksum", 32'(sum_a), 32'h9E1E);
    chk("midstart_queue_empty", 32'(q_a.size()), 0);

    // Reset while word 5 is being read
    push_a();
    start_a = 1'b1;
    next_cycle();
    start_a = 1'b0;
    repeat (10) next_cycle();
    chk("idx5_rd", {27'd0, bus_a.rom_cs, bus_a.rom_addr}, 32'h15);
    rst = 1'b1;
    #1;
    q_a.delete();
    chk("midrst_flags", {29'd0, halt_a, busy_a, done_a}, 32'b100);
    chk("midrst_strobes", {30'd0, bus_a.rom_cs, bus_a.ram_cs}, 0);
    chk("midrst_addr", {16'd0, bus_a.rom_addr, bus_a.ram_addr}, 0);
    chk("midrst_din_sum", {bus_a.ram_din, sum_a}, 0);
    next_cycle();
    push_a();
    rst = 1'b0;
    n = 0;
    while (!done_a && n < 100) begin
      next_cycle();
      n++;
    end
    chk("rerun_latency", 32'(n), 33);
    chk("rerun_checksum", 32'(sum_a), 32'h9E1E);
    chk("rerun_queue_empty", 32'(q_a.size()), 0);

    // Manual-start instance, RAM base near the top of the address space
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      chk($sformatf("b_idle_%0d", i), {28'd0, busy_b, halt_b, bus_b.rom_cs, done_b}, 32'b0100);
    end
    push_b();
    start_b = 1'b1;
    next_cycle();
    start_b = 1'b0;
    chk("b_start_rd", {26'd0, busy_b, bus_b.rom_cs, bus_b.rom_addr}, 32'h30);
    n = 1;
    while (!done_b && n < 100) begin
      next_cycle();
      n++;
    end
    chk("b_latency", 32'(n), 33);
    chk("b_checksum", 32'(sum_b), 32'h9E1E);
    chk("b_halt", 32'(halt_b), 0);
    chk("b_queue_empty", 32'(q_b.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got expired expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/boot_loader.md
# boot_loader

Boot-time copy engine that masters the 16-word boot ROM's read port (cs/we/addr/dout) and transfers its contents into main RAM before the CPU runs. It sits between the boot ROM, the RAM write port and the CPU's halt input. The CPU is held in halt from reset until the copy completes. A 16-bit running checksum is also reported.

## Interface
Parameters:
- WORDS, 16: number of ROM words copied; valid range 1..16.
- RAM_AW, 12: RAM address width.
- BASE, 0: RAM word address of the first copied word.
- AUTO_START, 1: when 1, the copy starts without `start`; when 0, it waits for `start`.

Ports:
- romclk  in  1  engine clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle copy request; sampled only in IDLE or DONE.
- rom_cs  out  1  ROM chip select.
- rom_we  out  1  ROM write enable; tied 0.
- rom_addr  out  4  ROM word address.
- rom_din  out  16  ROM write data; tied 0.
- rom_dout  in  16  ROM read data; valid in the same cycle rom_cs=1.
- ram_cs  out  1  RAM chip select.
- ram_we  out  1  RAM write enable.
- ram_addr  out  RAM_AW  RAM word address.
- ram_din  out  16  RAM write data.
- ram_wait  in  1  RAM stall; a write completes only in a cycle with ram_cs=1 and ram_wait=0.
- cpu_halt  out  1  holds the CPU.
- busy  out  1  copy in progress.
- done  out  1  copy finished; sticky until the next copy or reset.
- checksum  out  16  sum of copied words, modulo 2^16.

## Operation
FSM states: IDLE, RD, WR, DONE.
- Reset values:
  - state=IDLE, index=0, data register=0, checksum=0.
  - cpu_halt=1, busy=0, done=0.
  - All ROM and RAM strobes 0; rom_addr=0, ram_addr=0, ram_din=0.
- IDLE:
  - Go to RD if AUTO_START=1, or if start=1.
  - Clear checksum and index on leaving IDLE.
- RD:
  - Drive rom_cs=1, rom_we=0, rom_addr=index.
  - Capture rom_dout into the data register at the clock edge.
  - Go to WR.
- WR:
  - Drive ram_cs=1, ram_we=1, ram_addr=BASE+index, ram_din=data register.
  - If ram_wait=1: stay in WR, holding all outputs stable.
  - If ram_wait=0: add data into checksum. Then either go to DONE when index=WORDS-1, or increment index and go to RD.
- DONE:
  - done=1, cpu_halt=0, busy=0.
  - start=1 restarts the copy: go to RD, clear done and checksum, set cpu_halt=1, index=0.
- Output rules:
  - busy=1 exactly in RD and WR.
  - cpu_halt=0 only in DONE.
  - When not in their active state, the ROM and RAM strobes are 0.
- Address and width rules:
  - BASE+index is truncated to RAM_AW bits; wrap-around is permitted and not flagged.
  - checksum is an unsigned 16-bit sum; carry is discarded.
- Boundary behaviour:
  - start while busy: ignored.
  - start in IDLE with AUTO_START=1: no effect, since the copy already begins.
- Reset mid-copy: immediate return to the reset values; a partial RAM image is left as-is.

## Timing
- Each word takes 2 cycles (RD, WR) plus one cycle per ram_wait stall cycle.
- With no stalls and AUTO_START=1:
  - The first RD occurs in the first cycle after rst deasserts, plus the IDLE cycle.
  - DONE is entered 2·WORDS cycles after leaving IDLE.
- done, cpu_halt and checksum are registered; they change on the edge that enters DONE.
- rom_dout is sampled at the end of the RD cycle only. The ROM's output latch may hold it afterwards, but the engine does not rely on that.
- ROM and RAM are never selected in the same cycle.

## Structure
- Shared package `boot_pkg`:
  - state enum (IDLE, RD, WR, DONE);
  - ROM_WORDS=16;
  - BOOT_BASE default.
- Single module; no sub-module needed. Checksum and index counters are inline registers.

## Test plan
- Default ROM image, AUTO_START=1, ram_wait=0 -> RAM[0..7] = F200, 4000, F800, 1007, F400, 3010, 4000, 0007; RAM[8..15]=0; checksum=9E1E; done and cpu_halt=0 exactly 33 cycles after the rst deassert edge.
- ram_wait=1 for 3 cycles during word 2 -> ram_addr=2 and ram_din=F800 held for 4 cycles; final checksum still 9E1E; total time 3 cycles longer.
- AUTO_START=0 -> stays in IDLE with cpu_halt=1 for 10 cycles; a start pulse begins RD on the next cycle.
- rst pulsed while index=5 -> all outputs return to reset values immediately; after release the copy reruns from index 0 and ends with checksum 9E1E.
- start asserted mid-copy -> no effect; start in DONE -> done=0 and cpu_halt=1 on the next edge, then the full copy repeats.
- BASE=0xFFC, RAM_AW=12 -> addresses FFC, FFD, FFE, FFF, 000, ..., 00B written in order; no error raised.
